alu_shift_sequencer: RTL and testbench

Multi-cycle shift engine that sits on the issuing side of the ALU: it drives the ALU's operand and control inputs, consumes its accumulator and zero outputs, and turns the ALU's single-bit SLL/SRL operations into arbitrary-distance logical shifts. It accepts one shift request at a time from the execute stage, iterates one ALU shift per clock, and returns the registered result with a one-cycle done pulse.

---
 rtl/alu_shift_sequencer_if.sv | 30 +++
 rtl/alu_shift_sequencer.sv | 99 +++++++++
 tb/tb_alu_shift_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_shift_sequencer_if.sv
// Request/response and ALU-side signal bundle for the multi-cycle shift sequencer.
// "master" is the surrounding environment (execute stage plus ALU), "slave" the sequencer.
interface alu_shift_sequencer_if #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int SHAMT_WIDTH    = 6
);
    logic                      start_in;
    logic                      op_in;
    logic [DATAPATH_WIDTH-1:0] data_in;
    logic [SHAMT_WIDTH-1:0]    shamt_in;
    logic                      busy_out;
    logic                      done_out;
    logic [DATAPATH_WIDTH-1:0] result_out;
    logic                      zero_out;
    logic [DATAPATH_WIDTH-1:0] alu_a_out;
    logic [DATAPATH_WIDTH-1:0] alu_b_out;
    logic [3:0]                alu_ctrl_out;
    logic [DATAPATH_WIDTH-1:0] alu_accum_in;
    logic                      alu_zero_in;

    modport master (
        output start_in, op_in, data_in, shamt_in, alu_accum_in, alu_zero_in,
        input  busy_out, done_out, result_out, zero_out, alu_a_out, alu_b_out, alu_ctrl_out
    );

    modport slave (
        input  start_in, op_in, data_in, shamt_in, alu_accum_in, alu_zero_in,
        output busy_out, done_out, result_out, zero_out, alu_a_out, alu_b_out, alu_ctrl_out
    );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Iterates single-bit ALU SLL/SRL operations to perform arbitrary-distance logical shifts,
// one ALU shift per clock, with early exit once the working value has become zero.
module alu_shift_sequencer #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int SHAMT_WIDTH    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_shift_sequencer_if.slave sif
);

    localparam logic [3:0] ALU_OP_SLL  = 4'd8;
    localparam logic [3:0] ALU_OP_SRL  = 4'd9;
    localparam logic [3:0] ALU_OP_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [DATAPATH_WIDTH-1:0] work_q, work_d;
    logic [SHAMT_WIDTH-1:0]    count_q, count_d;
    logic                      op_q, op_d;
    logic [DATAPATH_WIDTH-1:0] result_q, result_d;
    logic                      zero_q, zero_d;
    logic                      last_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            count_q  <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // A zero working value cannot change under further logical shifts, so stop early.
    assign last_shift = (count_q == SHAMT_WIDTH'(1)) || sif.alu_zero_in;

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (sif.start_in) begin
                    work_d  = sif.data_in;
                    count_d = sif.shamt_in;
                    op_d    = sif.op_in;
                    if (sif.shamt_in != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d  = DONE;
                        result_d = sif.data_in;
                        zero_d   = (sif.data_in == '0);
                    end
                end
            end
            SHIFT: begin
                work_d  = sif.alu_accum_in;
                count_d = count_q - SHAMT_WIDTH'(1);
                if (last_shift) begin
                    state_d  = DONE;
                    result_d = sif.alu_accum_in;
                    zero_d   = sif.alu_zero_in;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sif.busy_out     = (state_q != IDLE);
    assign sif.done_out     = (state_q == DONE);
    assign sif.result_out   = result_q;
    assign sif.zero_out     = zero_q;
    assign sif.alu_a_out    = work_q;
    assign sif.alu_b_out    = '0;
    assign sif.alu_ctrl_out = (state_q == SHIFT) ? (op_q ? ALU_OP_SRL : ALU_OP_SLL) : ALU_OP_NONE;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: directed cases plus randomized shifts against a behavioural model.
module tb_alu_shift_sequencer;

    localparam int DW = 64;
    localparam int SW = 6;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [DW-1:0] exp_result_q;
    logic          exp_zero_q;

    alu_shift_sequencer_if #(.DATAPATH_WIDTH(DW), .SHAMT_WIDTH(SW)) ifc ();

    alu_shift_sequencer #(.DATAPATH_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (ifc.slave)
    );

    // Behavioural ALU: single-bit logical shifts, default opcode yields zero.
    assign ifc.alu_accum_in = (ifc.alu_ctrl_out == 4'd8) ? (ifc.alu_a_out << 1) :
                              (ifc.alu_ctrl_out == 4'd9) ? (ifc.alu_a_out >> 1) : '0;
    assign ifc.alu_zero_in  = (ifc.alu_accum_in == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] shift_by(input logic op, input logic [DW-1:0] v, input int n);
        return op ? (v >> n) : (v << n);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},   64'(ifc.busy_out),     64'(0));
        check_eq({tag, "_done"},   64'(ifc.done_out),     64'(0));
        check_eq({tag, "_result"}, ifc.result_out,        64'(0));
        check_eq({tag, "_zero"},   64'(ifc.zero_out),     64'(0));
        check_eq({tag, "_ctrl"},   64'(ifc.alu_ctrl_out), 64'hF);
        check_eq({tag, "_alu_a"},  ifc.alu_a_out,         64'(0));
        check_eq({tag, "_alu_b"},  ifc.alu_b_out,         64'(0));
    endtask

    // One full request: issue at E0, walk the expected SHIFT cycles, DONE pulse, return to IDLE.
    task automatic run_op(input logic op, input logic [DW-1:0] data, input logic [SW-1:0] shamt,
                          input bit poke);
        int            k;
        logic [DW-1:0] final_res;
        k = 0;
        for (int j = 1; j <= int'(shamt) && k == 0; j++)
            if (shift_by(op, data, j) == '0) k = j;
        if (k == 0) k = int'(shamt);
        final_res = shift_by(op, data, int'(shamt));

        @(negedge clk);
        ifc.start_in = 1'b1;
        ifc.op_in    = op;
        ifc.data_in  = data;
        ifc.shamt_in = shamt;
        @(posedge clk);
        #1;
        ifc.start_in = 1'b0;
        ifc.op_in    = ~op;
        ifc.data_in  = {$urandom, $urandom};
        ifc.shamt_in = SW'($urandom);

        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            if (poke && j == 1) ifc.start_in = 1'b1;
            check_eq("shift_busy",   64'(ifc.busy_out),     64'(1));
            check_eq("shift_done",   64'(ifc.done_out),     64'(0));
            check_eq("shift_ctrl",   64'(ifc.alu_ctrl_out), op ? 64'd9 : 64'd8);
            check_eq("shift_alu_a",  ifc.alu_a_out,         shift_by(op, data, j - 1));
            check_eq("shift_alu_b",  ifc.alu_b_out,         64'(0));
            check_eq("shift_result", ifc.result_out,        exp_result_q);
            check_eq("shift_zero",   64'(ifc.zero_out),     64'(exp_zero_q));
        end

        @(negedge clk);
        ifc.start_in = 1'b0;
        exp_result_q = final_res;
        exp_zero_q   = (final_res == '0);
        check_eq("done_pulse",  64'(ifc.done_out),     64'(1));
        check_eq("done_busy",   64'(ifc.busy_out),     64'(1));
        check_eq("done_result", ifc.result_out,        exp_result_q);
        check_eq("done_zero",   64'(ifc.zero_out),     64'(exp_zero_q));
        check_eq("done_ctrl",   64'(ifc.alu_ctrl_out), 64'hF);
        check_eq("done_alu_a",  ifc.alu_a_out,         shift_by(op, data, k));

        @(negedge clk);
        check_eq("idle_done",   64'(ifc.done_out), 64'(0));
        check_eq("idle_busy",   64'(ifc.busy_out), 64'(0));
        check_eq("idle_result", ifc.result_out,    exp_result_q);
        check_eq("idle_zero",   64'(ifc.zero_out), 64'(exp_zero_q));
    endtask

    initial begin
        logic [DW-1:0] rdata;
        vectors      = 0;
        miscompares  = 0;
        exp_result_q = '0;
        exp_zero_q   = 1'b0;
        ifc.start_in = 1'b0;
        ifc.op_in    = 1'b0;
        ifc.data_in  = '0;
        ifc.shamt_in = '0;
        rst_n        = 1'b1;

        // Reset held with a request pending.
        #2;
        rst_n        = 1'b0;
        ifc.start_in = 1'b1;
        ifc.data_in  = 64'hDEAD_BEEF_0000_0001;
        ifc.shamt_in = 6'd5;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        ifc.start_in = 1'b0;
        rst_n        = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("post_reset");

        run_op(1'b0, 64'h1, 6'd63, 1'b0);
        check_eq("sll_63", ifc.result_out, 64'h8000_0000_0000_0000);
        run_op(1'b1, 64'hF0F0_0000_0000_00FF, 6'd4, 1'b1);
        check_eq("srl_4", ifc.result_out, 64'h0F0F_0000_0000_000F);
        run_op(1'b0, 64'h0, 6'd0, 1'b0);
        check_eq("zero_shamt_zero", 64'(ifc.zero_out), 64'(1));
        run_op(1'b1, 64'h3, 6'd40, 1'b0);
        check_eq("early_zero", 64'(ifc.zero_out), 64'(1));

        // Abort mid-SHIFT with reset, then a fresh request.
        @(negedge clk);
        ifc.start_in = 1'b1;
        ifc.op_in    = 1'b0;
        ifc.data_in  = 64'h5;
        ifc.shamt_in = 6'd20;
        @(posedge clk);
        #1;
        ifc.start_in = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_done", 64'(ifc.done_out), 64'(0));
        end
        rst_n        = 1'b1;
        exp_result_q = '0;
        exp_zero_q   = 1'b0;
        run_op(1'b0, 64'h5, 6'd2, 1'b0);
        check_eq("after_abort", ifc.result_out, 64'h14);

        for (int t = 0; t < 40; t++) begin
            rdata = {$urandom, $urandom};
            if (t % 3 == 1) rdata = rdata >> $urandom_range(63, 40);
            if (t % 3 == 2) rdata = rdata << $urandom_range(63, 40);
            run_op(1'($urandom), rdata, SW'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
